noc_fifo_pm_rd: RTL
===================

NOC_FIFO_PM_RD -- requirements
Module: noc_fifo_pm_rd

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default NOC_ASYNC_FIFO_PACKET_SIZE (noc_parameter.vh), giving the packet width.
REQ-002 SHALL have parameter AWIDTH, default NOC_ASYNC_FIFO_AWIDTH, giving log2 of the FIFO depth; pointers are AWIDTH+1 bits.
REQ-003 SHALL have port clk_i, input, 1, the single PM-domain clock; all state is on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, the reset; it is asynchronous and active-high.
REQ-005 SHALL have port noc_fifo_in_data_i, input, PACKET_SIZE, the packet at raddr, muxed by the write-side memory.
REQ-006 SHALL have port noc_fifo_in_waddr_i, input, AWIDTH+1, the Gray write pointer from the NoC clock domain.
REQ-007 SHALL have port noc_fifo_in_raddr_o, output, AWIDTH+1, the registered Gray read pointer returned to the write side.
REQ-008 SHALL have port pkt_data_o, output, PACKET_SIZE, the packet presented to the core.
REQ-009 SHALL have port pkt_valid_o, output, 1, which is high while pkt_data_o holds a packet.
REQ-010 SHALL have port pkt_ready_i, input, 1, the consumer accept signal.
REQ-011 SHALL have port fill_level_o, output, AWIDTH+1, the count of FIFO entries not yet read.

Function
REQ-012 SHALL synchronise noc_fifo_in_waddr_i through a 2-flop chain (wptr_sync) before any use.
REQ-013 SHALL hold the read pointer as a binary register rptr_bin plus a Gray register driving noc_fifo_in_raddr_o; the output is glitch-free, with no combinational path to it.
REQ-014 SHALL treat the FIFO as empty iff wptr_sync equals noc_fifo_in_raddr_o (full Gray compare, including the wrap bit).
REQ-015 SHALL use load = !empty && (!pkt_valid_o || pkt_ready_i).
REQ-016 On load, the same edge SHALL do all of the following: pkt_data_o <= noc_fifo_in_data_i; pkt_valid_o <= 1; rptr_bin <= rptr_bin+1; Gray pointer <= gray(rptr_bin+1).
REQ-017 When pkt_valid_o && pkt_ready_i && empty, pkt_valid_o SHALL go to 0 on the next edge.
REQ-018 While pkt_valid_o && !pkt_ready_i, pkt_data_o and the pointer SHALL hold unchanged.
REQ-019 SHALL sustain one packet per cycle with pkt_ready_i held high and the FIFO non-empty, with no bubbles.
REQ-020 Latency SHALL be as follows: pkt_valid_o rises on the 3rd rising edge after a waddr change, when the output stage is empty.
REQ-021 Pointer arithmetic SHALL be modulo 2^(AWIDTH+1); Gray wraps from gray(2^(AWIDTH+1)-1) to 0 with packet order preserved.
REQ-022 Simultaneous accept and load SHALL replace the packet without pkt_valid_o dropping.
REQ-023 Data integrity SHALL rely on the write side updating waddr only after the entry is written; the read side performs no data checking.

Reset
REQ-024 reset_i high SHALL asynchronously clear the sync flops, rptr_bin, the Gray pointer, pkt_valid_o, pkt_data_o and fill_level_o to 0.
REQ-025 A reset mid-transfer SHALL discard any held packet; the write side is reset by the same system reset, and no recovery of in-flight entries is provided.
REQ-026 Reset release SHALL take effect on the first clk_i edge with reset_i low; loads begin no earlier than the 3rd edge.

Configuration
REQ-027 Macro NOC_FIFO_PM_RD_LEVEL_EN defined: fill_level_o SHALL be a register updated each cycle to gray2bin(wptr_sync) - rptr_bin (mod 2^(AWIDTH+1)), range 0..2^AWIDTH, excluding the output stage.
REQ-028 Macro NOC_FIFO_PM_RD_LEVEL_EN undefined: fill_level_o SHALL be constant 0, with no Gray-to-binary converter or subtractor synthesised.

Verification (AWIDTH=3)
REQ-029 Reset: assert reset_i between edges -> immediately raddr_o=4'b0000, pkt_valid_o=0, fill_level_o=0.
REQ-030 Single packet: data_i=32'hA5A50001, waddr 0000->0001, pkt_ready_i=0 -> on edge 3, pkt_valid_o=1, pkt_data_o=A5A50001, raddr_o=0001; then ready=1 for 1 cycle -> valid=0.
REQ-031 Burst: waddr=gray(8)=1100, ready=1 -> 8 packets in 8 consecutive cycles, raddr_o ends 1100, no gaps; level 8->0 (LEVEL_EN).
REQ-032 Backpressure: 3 packets written, ready=0 -> one packet held stable, raddr_o=0001, fill_level_o=2; ready=1 -> remaining two delivered in order.
REQ-033 Wrap: 20 packets in bursts of 8/8/4 -> raddr_o passes 1000->0000, all 20 payloads delivered in order.
REQ-034 Mid-operation reset: reset pulsed with valid=1 and level=5 -> all outputs 0 immediately; after re-init of both sides, a new packet is delivered with 3-edge latency.

Source files
------------

// File: rtl/noc_fifo_pm_rd.sv
// PM-domain read side of the NoC async FIFO: Gray write-pointer sync, read pointer and one-entry output stage.
// Optional macro NOC_FIFO_PM_RD_LEVEL_EN adds a registered fill level; otherwise fill_level_o is tied to 0.
`ifndef NOC_ASYNC_FIFO_PACKET_SIZE
`define NOC_ASYNC_FIFO_PACKET_SIZE 32
`endif
`ifndef NOC_ASYNC_FIFO_AWIDTH
`define NOC_ASYNC_FIFO_AWIDTH 3
`endif

module noc_fifo_pm_rd #(
  parameter int PACKET_SIZE = `NOC_ASYNC_FIFO_PACKET_SIZE,
  parameter int AWIDTH      = `NOC_ASYNC_FIFO_AWIDTH
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [PACKET_SIZE-1:0] noc_fifo_in_data_i,
  input  logic [AWIDTH:0]        noc_fifo_in_waddr_i,
  output logic [AWIDTH:0]        noc_fifo_in_raddr_o,
  output logic [PACKET_SIZE-1:0] pkt_data_o,
  output logic                   pkt_valid_o,
  input  logic                   pkt_ready_i,
  output logic [AWIDTH:0]        fill_level_o
);

  localparam int PW = AWIDTH + 1;

  logic [PW-1:0] wptr_meta;
  logic [PW-1:0] wptr_sync;
  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] rptr_bin_next;
  logic [PW-1:0] rptr_gray;
  logic          empty;
  logic          load;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Two-flop synchroniser for the Gray write pointer coming from the NoC clock.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_meta <= '0;
      wptr_sync <= '0;
    end else begin
      wptr_meta <= noc_fifo_in_waddr_i;
      wptr_sync <= wptr_meta;
    end
  end

  assign empty         = (wptr_sync == rptr_gray);
  assign load          = !empty && (!pkt_valid_o || pkt_ready_i);
  assign rptr_bin_next = rptr_bin + PW'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
    end else if (load) begin
      rptr_bin  <= rptr_bin_next;
      rptr_gray <= bin2gray(rptr_bin_next);
    end
  end

  assign noc_fifo_in_raddr_o = rptr_gray;

  // Output stage: a load replaces the held packet, an accept with nothing behind it drains it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pkt_valid_o <= 1'b0;
      pkt_data_o  <= '0;
    end else if (load) begin
      pkt_valid_o <= 1'b1;
      pkt_data_o  <= noc_fifo_in_data_i;
    end else if (pkt_ready_i) begin
      pkt_valid_o <= 1'b0;
    end
  end

`ifdef NOC_FIFO_PM_RD_LEVEL_EN
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Entries still in the FIFO memory; the packet in the output stage is not counted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fill_level_o <= '0;
    end else begin
      fill_level_o <= gray2bin(wptr_sync) - rptr_bin;
    end
  end
`else
  assign fill_level_o = '0;
`endif

endmodule
